// File: rtl/adpll_pkg.sv
// Shared ADPLL definitions: DCO code width/reset value, loop FSM states and code field slices.
package adpll_pkg;
  localparam int CODE_W = 8;
  localparam logic [CODE_W-1:0] CODE_INIT = 8'h80;

  typedef enum logic [1:0] {IDLE, SETTLE, MEASURE, UPDATE} lock_state_t;

  function automatic logic [5:0] sel_cel(input logic [CODE_W-1:0] c);
    return c[7:2];
  endfunction

  function automatic logic [1:0] sel_buf(input logic [CODE_W-1:0] c);
    return c[1:0];
  endfunction
endpackage

// File: rtl/dco_freq_lock_ctrl_if.sv
// Control/status bundle between a host and the DCO frequency-lock controller.
interface dco_freq_lock_ctrl_if #(parameter int CNT_W = 12);
  import adpll_pkg::*;

  logic              run;
  logic [CNT_W-1:0]  target_cnt;
  logic [CODE_W-1:0] code;
  logic              dco_enable;
  logic [CNT_W-1:0]  meas_cnt;
  logic              meas_valid;
  logic              locked;
  logic              busy;

  modport master (output run, target_cnt,
                  input  code, dco_enable, meas_cnt, meas_valid, locked, busy);
  modport slave  (input  run, target_cnt,
                  output code, dco_enable, meas_cnt, meas_valid, locked, busy);
endinterface

// File: rtl/dco_edge_sync.sv
// Brings an asynchronous clock-like signal into the clk domain and emits a 1-cycle pulse per rising edge.
module dco_edge_sync (
  input  logic clk,
  input  logic rst,
  input  logic sig,
  output logic rise
);
  logic [2:0] sync;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync <= '0;
    else     sync <= {sync[1:0], sig};
  end

  assign rise = sync[1] & ~sync[2];
endmodule

// File: rtl/dco_freq_lock_ctrl.sv
// Frequency-acquisition loop: counts DCO edges per window and nudges the DCO code toward target_cnt.
// state   | meaning
// IDLE    | loop off, DCO disabled, code held
// SETTLE  | DCO settling after enable or code change, edges ignored
// MEASURE | counting DCO edges for WIN_CYCLES cycles
// UPDATE  | compare count with target, step code, update lock
module dco_freq_lock_ctrl
  import adpll_pkg::*;
#(
  parameter int WIN_CYCLES = 1024,
  parameter int CNT_W      = 12,
  parameter int SETTLE_CYC = 16,
  parameter int GAIN_SHIFT = 2,
  parameter int MAX_STEP   = 16,
  parameter int LOCK_TOL   = 2,
  parameter int LOCK_WINS  = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic dco_clk,
  dco_freq_lock_ctrl_if.slave bus
);
  localparam int TMR_W  = $clog2(WIN_CYCLES > SETTLE_CYC ? WIN_CYCLES : SETTLE_CYC);
  localparam int IT_W   = $clog2(LOCK_WINS + 1);
  localparam int STEP_W = $clog2(MAX_STEP + 1);
  localparam int SUM_W  = CODE_W + 2;

  lock_state_t              state;
  logic [TMR_W-1:0]         tmr;
  logic [CNT_W-1:0]         edge_cnt, edge_cnt_nxt;
  logic [IT_W-1:0]          intol, intol_nxt;
  logic                     edge_rise;
  logic signed [CNT_W:0]    err;
  logic [CNT_W:0]           abs_err, shifted;
  logic                     in_tol, out_hyst, locked_nxt;
  logic [STEP_W-1:0]        step_mag;
  logic [SUM_W-1:0]         step_abs;
  logic signed [SUM_W-1:0]  code_sum;
  logic [CODE_W-1:0]        code_nxt;

  dco_edge_sync u_edge_sync (.clk(clk), .rst(rst), .sig(dco_clk), .rise(edge_rise));

  always_comb begin
    edge_cnt_nxt = edge_cnt;
    if (edge_rise && edge_cnt != '1) edge_cnt_nxt = edge_cnt + 1'b1;
  end

  always_comb begin
    err      = $signed({1'b0, bus.meas_cnt}) - $signed({1'b0, bus.target_cnt});
    abs_err  = err[CNT_W] ? $unsigned(-err) : $unsigned(err);
    shifted  = abs_err >> GAIN_SHIFT;
    in_tol   = abs_err <= (CNT_W+1)'(LOCK_TOL);
    out_hyst = abs_err > (CNT_W+1)'(2 * LOCK_TOL);

    if (in_tol)                               step_mag = '0;
    else if (shifted > (CNT_W+1)'(MAX_STEP))  step_mag = STEP_W'(MAX_STEP);
    else if (shifted == '0)                   step_mag = STEP_W'(1);
    else                                      step_mag = shifted[STEP_W-1:0];

    step_abs = SUM_W'(step_mag);
    code_sum = err[CNT_W] ? $signed({2'b00, bus.code}) - $signed(step_abs)
                          : $signed({2'b00, bus.code}) + $signed(step_abs);

    // Saturate rather than wrap so the DCO never jumps across its whole range.
    if (code_sum[SUM_W-1])      code_nxt = '0;
    else if (code_sum[SUM_W-2]) code_nxt = '1;
    else                        code_nxt = code_sum[CODE_W-1:0];

    if (!in_tol)                          intol_nxt = '0;
    else if (intol == IT_W'(LOCK_WINS))   intol_nxt = intol;
    else                                  intol_nxt = intol + 1'b1;

    if (intol_nxt == IT_W'(LOCK_WINS)) locked_nxt = 1'b1;
    else if (out_hyst)                 locked_nxt = 1'b0;
    else                               locked_nxt = bus.locked;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      tmr            <= '0;
      edge_cnt       <= '0;
      intol          <= '0;
      bus.code       <= CODE_INIT;
      bus.dco_enable <= 1'b0;
      bus.meas_cnt   <= '0;
      bus.meas_valid <= 1'b0;
      bus.locked     <= 1'b0;
      bus.busy       <= 1'b0;
    end else begin
      bus.meas_valid <= 1'b0;
      if (state != IDLE && !bus.run) begin
        state          <= IDLE;
        bus.dco_enable <= 1'b0;
        bus.busy       <= 1'b0;
        bus.locked     <= 1'b0;
        intol          <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (bus.run) begin
              state          <= SETTLE;
              tmr            <= TMR_W'(SETTLE_CYC - 1);
              bus.dco_enable <= 1'b1;
              bus.busy       <= 1'b1;
            end
          end
          SETTLE: begin
            edge_cnt <= '0;
            if (tmr == '0) begin
              state <= MEASURE;
              tmr   <= TMR_W'(WIN_CYCLES - 1);
            end else begin
              tmr <= tmr - 1'b1;
            end
          end
          MEASURE: begin
            edge_cnt <= edge_cnt_nxt;
            if (tmr == '0) begin
              state          <= UPDATE;
              bus.meas_cnt   <= edge_cnt_nxt;
              bus.meas_valid <= 1'b1;
            end else begin
              tmr <= tmr - 1'b1;
            end
          end
          UPDATE: begin
            bus.code   <= code_nxt;
            intol      <= intol_nxt;
            bus.locked <= locked_nxt;
            state      <= SETTLE;
            tmr        <= TMR_W'(SETTLE_CYC - 1);
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_dco_freq_lock_ctrl.sv
// Bench for dco_freq_lock_ctrl: directed window table, randomized windows against a behavioural loop model.
module tb_dco_freq_lock_ctrl;
  import adpll_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic dco_clk;

  dco_freq_lock_ctrl_if #(.CNT_W(12)) bus();

  dco_freq_lock_ctrl #(.CNT_W(12)) dut (
    .clk(clk), .rst(rst), .dco_clk(dco_clk), .bus(bus.slave)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int m_code, m_intol;
  bit m_locked;

  typedef struct {
    int n;
    int target;
    int reps;
    int exp_code;
    bit exp_locked;
  } vec_t;

  vec_t tbl[14];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %0d expected %0d", name, act, exp);
    end
  endtask

  // Loop behaviour computed from the rules: error, gain, step clamp, code clamp, lock with hysteresis.
  task automatic model_update(input int n, input int target);
    int e, mag, step;
    e = n - target;
    mag = (e < 0) ? -e : e;
    if (mag <= 2) begin
      step = 0;
      m_intol = (m_intol < 4) ? m_intol + 1 : 4;
    end else begin
      step = mag / 4;
      if (step < 1) step = 1;
      if (step > 16) step = 16;
      if (e < 0) step = -step;
      m_intol = 0;
    end
    m_code = m_code + step;
    if (m_code < 0) m_code = 0;
    if (m_code > 255) m_code = 255;
    if (m_intol == 4) m_locked = 1'b1;
    else if (mag > 4) m_locked = 1'b0;
  endtask

  // Entered half a cycle after the edge that starts SETTLE; returns half a cycle after the edge leaving UPDATE.
  task automatic run_window(input int n, input int target, input string tag);
    int waited;
    int lat;
    bus.target_cnt = 12'(target);
    repeat (20) @(negedge clk);
    for (int k = 0; k < n; k++) begin
      dco_clk = 1'b1;
      repeat (2) @(negedge clk);
      dco_clk = 1'b0;
      repeat (2) @(negedge clk);
    end
    waited = 0;
    while (!bus.meas_valid && waited < 1200) begin
      @(negedge clk);
      waited++;
    end
    if (!bus.meas_valid) begin
      checks++;
      errors++;
      $display("FAIL %s timeout no meas_valid after %0d cycles", tag, waited);
      return;
    end
    lat = 20 + 4 * n + waited;
    check({tag, " latency"}, lat, 1040);
    check({tag, " meas_cnt"}, int'(bus.meas_cnt), n);
    check({tag, " code_hold"}, int'(bus.code), m_code);
    model_update(n, target);
    @(negedge clk);
    check({tag, " code"}, int'(bus.code), m_code);
    check({tag, " locked"}, int'(bus.locked), int'(m_locked));
  endtask

  initial begin
    int tgt, n;
    bit saw_valid;

    tbl[0]  = '{120, 100, 1,  'h85, 1'b0};
    tbl[1]  = '{103, 100, 1,  134,  1'b0};
    tbl[2]  = '{102, 100, 1,  134,  1'b0};
    tbl[3]  = '{99,  100, 1,  134,  1'b0};
    tbl[4]  = '{100, 100, 1,  134,  1'b0};
    tbl[5]  = '{101, 100, 1,  134,  1'b1};
    tbl[6]  = '{103, 100, 1,  135,  1'b1};
    tbl[7]  = '{105, 100, 1,  136,  1'b0};
    tbl[8]  = '{20,  100, 8,  8,    1'b0};
    tbl[9]  = '{80,  100, 1,  3,    1'b0};
    tbl[10] = '{20,  100, 1,  0,    1'b0};
    tbl[11] = '{180, 100, 15, 240,  1'b0};
    tbl[12] = '{156, 100, 1,  'hFE, 1'b0};
    tbl[13] = '{180, 100, 1,  'hFF, 1'b0};

    rst = 1'b1;
    dco_clk = 1'b0;
    bus.run = 1'b0;
    bus.target_cnt = '0;
    m_code = 'h80;
    m_intol = 0;
    m_locked = 1'b0;
    repeat (3) @(negedge clk);
    check("rst code", int'(bus.code), 'h80);
    check("rst dco_enable", int'(bus.dco_enable), 0);
    check("rst meas_cnt", int'(bus.meas_cnt), 0);
    check("rst meas_valid", int'(bus.meas_valid), 0);
    check("rst locked", int'(bus.locked), 0);
    check("rst busy", int'(bus.busy), 0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("idle code", int'(bus.code), 'h80);

    bus.run = 1'b1;
    @(negedge clk);
    check("start busy", int'(bus.busy), 1);
    check("start dco_enable", int'(bus.dco_enable), 1);

    for (int i = 0; i < 14; i++) begin
      for (int r = 0; r < tbl[i].reps; r++)
        run_window(tbl[i].n, tbl[i].target, $sformatf("tbl%0d.%0d", i, r));
      check($sformatf("tbl%0d code", i), int'(bus.code), tbl[i].exp_code);
      check($sformatf("tbl%0d locked", i), int'(bus.locked), int'(tbl[i].exp_locked));
    end

    for (int i = 0; i < 10; i++) begin
      tgt = int'($urandom_range(60, 200));
      n = tgt + int'($urandom_range(0, 40)) - 20;
      run_window(n, tgt, $sformatf("rnd%0d", i));
    end

    // Abort around MEASURE cycle 500.
    repeat (17 + 500) @(negedge clk);
    bus.run = 1'b0;
    @(negedge clk);
    m_locked = 1'b0;
    m_intol = 0;
    check("abort busy", int'(bus.busy), 0);
    check("abort dco_enable", int'(bus.dco_enable), 0);
    check("abort locked", int'(bus.locked), 0);
    check("abort code", int'(bus.code), m_code);
    saw_valid = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (bus.meas_valid) saw_valid = 1'b1;
    end
    check("abort no meas_valid", int'(saw_valid), 0);
    check("abort code held", int'(bus.code), m_code);

    bus.run = 1'b1;
    @(negedge clk);
    run_window(250, 250, "restart");
    for (int i = 0; i < 3; i++)
      run_window(150, 150, $sformatf("relock%0d", i));
    check("relock locked", int'(bus.locked), 1);

    // Async reset in the middle of a measurement window.
    repeat (600) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("mid rst code", int'(bus.code), 'h80);
    check("mid rst dco_enable", int'(bus.dco_enable), 0);
    check("mid rst locked", int'(bus.locked), 0);
    check("mid rst busy", int'(bus.busy), 0);
    bus.run = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("post rst busy", int'(bus.busy), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
